ram_sdp_be: RTL and testbench

- Parametrised simple dual-port synchronous RAM with one write port and one read port. Both ports are usable in the same cycle.
- Adds per-byte write enables, a 1- or 2-cycle read pipeline with a valid strobe, selectable read-during-write behaviour, and a post-reset hardware clear engine.
- Used as generic data/scratch storage for the datapath, and as the successor to the single-port 512x32 store.

---
 rtl/ram_sdp_be.sv | 172 +++++++++++++++++
 tb/tb_ram_sdp_be.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_be.sv
// ram_sdp_be
// Simple dual-port synchronous RAM. It has one write port with per-byte
// enables and one read port. Both ports can be used in the same cycle.
// After reset, an optional clear engine writes zero to every word. The
// user ports are ignored while that engine runs.
//
// Ports
//   clock    : single clock; all logic updates on the rising edge
//   reset_n  : synchronous, active-low reset
//   wEn      : write enable
//   wAddr    : write address; addresses at or above DEPTH are dropped
//   wDat     : write data
//   wBe      : byte enables; bit i covers wDat[8i+7:8i]
//   rEn      : read enable
//   rAddr    : read address; addresses at or above DEPTH return zero
//   rDat     : read data; holds its last value between reads
//   rValid   : one-cycle strobe marking rDat as valid
//   busy     : clear engine running
module ram_sdp_be #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 9,
   parameter int DEPTH    = 512,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0,
   parameter int CLEAR_EN = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  wEn,
   input  logic [ADDR_W-1:0]     wAddr,
   input  logic [DATA_W-1:0]     wDat,
   input  logic [DATA_W/8-1:0]   wBe,
   input  logic                  rEn,
   input  logic [ADDR_W-1:0]     rAddr,
   output logic [DATA_W-1:0]     rDat,
   output logic                  rValid,
   output logic                  busy
);

   localparam int BE_W = DATA_W / 8;
   // One extra bit lets DEPTH == 2**ADDR_W be represented in the range compare.
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t              state;
   state_t              nextState;
   logic [ADDR_W-1:0]   clearPtr;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wrHit;
   logic                rdAccept;
   logic                rdInRange;
   logic [DATA_W-1:0]   oldWord;
   logic [DATA_W-1:0]   mergedWord;
   logic [DATA_W-1:0]   rdWord;
   logic [DATA_W-1:0]   s1Dat;
   logic                s1Valid;

   // State register. Reset enters CLEAR when the clear engine is enabled.
   // Otherwise the memory is usable immediately.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= (CLEAR_EN != 0) ? CLEAR : READY;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. The edge that clears the last word hands over to READY.
   // READY is left only through reset.
   always_comb begin
      nextState = state;
      if (state == CLEAR && clearPtr == LAST_ADDR) begin
         nextState = READY;
      end
   end

   assign busy = (state == CLEAR);

   // The clear pointer walks the whole array once per reset release.
   // It restarts from zero on every reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         clearPtr <= '0;
      end else if (state == CLEAR) begin
         clearPtr <= clearPtr + 1'b1;
      end
   end

   assign wrHit     = (state == READY) && wEn && ({1'b0, wAddr} < DEPTH_C);
   assign rdAccept  = (state == READY) && rEn;
   assign rdInRange = ({1'b0, rAddr} < DEPTH_C);

   // Storage array. Reset does not touch it. While clearing, only the
   // engine writes. Otherwise, bytes selected by wBe are updated.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         if (state == CLEAR) begin
            mem[clearPtr] <= '0;
         end else if (wrHit) begin
            for (int i = 0; i < BE_W; i++) begin
               if (wBe[i]) begin
                  mem[wAddr][8*i +: 8] <= wDat[8*i +: 8];
               end
            end
         end
      end
   end

   // Read word selection. Out-of-range reads return zero. On a same-address
   // collision in RDW_MODE 1, the read returns the word as it will look
   // after the write: new bytes where enabled, old bytes elsewhere.
   always_comb begin
      oldWord    = '0;
      mergedWord = '0;
      rdWord     = '0;
      if (rdInRange) begin
         oldWord = mem[rAddr];
      end
      for (int i = 0; i < BE_W; i++) begin
         mergedWord[8*i +: 8] = wBe[i] ? wDat[8*i +: 8] : oldWord[8*i +: 8];
      end
      if (RDW_MODE == 1 && wrHit && wAddr == rAddr) begin
         rdWord = mergedWord;
      end else begin
         rdWord = oldWord;
      end
   end

   // First read stage. Reset clears the stage, which discards in-flight reads.
   // The data holds when no read is accepted.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1Dat   <= '0;
         s1Valid <= 1'b0;
      end else begin
         s1Valid <= rdAccept;
         if (rdAccept) begin
            s1Dat <= rdWord;
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : gLat2
         logic [DATA_W-1:0] s2Dat;
         logic              s2Valid;

         // Extra output register stage for two-cycle read latency.
         always_ff @(posedge clock) begin
            if (!reset_n) begin
               s2Dat   <= '0;
               s2Valid <= 1'b0;
            end else begin
               s2Valid <= s1Valid;
               if (s1Valid) begin
                  s2Dat <= s1Dat;
               end
            end
         end

         assign rDat   = s2Dat;
         assign rValid = s2Valid;
      end else begin : gLat1
         assign rDat   = s1Dat;
         assign rValid = s1Valid;
      end
   endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// tb_ram_sdp_be
// Directed bench for ram_sdp_be. Three instances share one clock:
//   dutA : defaults (RD_LAT 1, old data on collision, clear enabled)
//   dutB : RD_LAT 2, new (merged) data on collision, clear enabled
//          dutA and dutB are driven from the same stimulus signals.
//   dutC : DEPTH 300, clear disabled, driven from its own signals
module tb_ram_sdp_be;

   logic        clock;
   logic        resetN;
   logic        wEn;
   logic [8:0]  wAddr;
   logic [31:0] wDat;
   logic [3:0]  wBe;
   logic        rEn;
   logic [8:0]  rAddr;
   logic [31:0] rDatA, rDatB, rDatC;
   logic        rValidA, rValidB, rValidC;
   logic        busyA, busyB, busyC;

   logic        cResetN;
   logic        cWEn;
   logic [8:0]  cWAddr;
   logic [31:0] cWDat;
   logic [3:0]  cWBe;
   logic        cREn;
   logic [8:0]  cRAddr;

   int checks   = 0;
   int failures = 0;

   ram_sdp_be #(.RD_LAT(1), .RDW_MODE(0), .CLEAR_EN(1)) dutA (
      .clock(clock), .reset_n(resetN), .wEn(wEn), .wAddr(wAddr), .wDat(wDat),
      .wBe(wBe), .rEn(rEn), .rAddr(rAddr), .rDat(rDatA), .rValid(rValidA), .busy(busyA)
   );

   ram_sdp_be #(.RD_LAT(2), .RDW_MODE(1), .CLEAR_EN(1)) dutB (
      .clock(clock), .reset_n(resetN), .wEn(wEn), .wAddr(wAddr), .wDat(wDat),
      .wBe(wBe), .rEn(rEn), .rAddr(rAddr), .rDat(rDatB), .rValid(rValidB), .busy(busyB)
   );

   ram_sdp_be #(.DEPTH(300), .ADDR_W(9), .CLEAR_EN(0)) dutC (
      .clock(clock), .reset_n(cResetN), .wEn(cWEn), .wAddr(cWAddr), .wDat(cWDat),
      .wBe(cWBe), .rEn(cREn), .rAddr(cRAddr), .rDat(rDatC), .rValid(rValidC), .busy(busyC)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge. Outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive one cycle of shared stimulus for dutA and dutB, then idle the enables.
   task automatic applyStimulus(input logic we, input logic [8:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic re, input logic [8:0] ra);
      wEn = we; wAddr = wa; wDat = wd; wBe = be; rEn = re; rAddr = ra;
      tick();
      wEn = 1'b0; rEn = 1'b0;
   endtask

   // Count edges while the clear engine is busy, within a cycle budget.
   // Any rValid seen during the clear is counted as spurious.
   task automatic countBusy(output int n, output int spurious);
      n = 0;
      spurious = 0;
      while (busyA && n < 2000) begin
         tick();
         n++;
         if (rValidA || rValidB) spurious++;
      end
   endtask

   initial begin
      int n;
      int spurious;

      resetN = 1'b0; wEn = 1'b0; wAddr = '0; wDat = '0; wBe = '0; rEn = 1'b0; rAddr = '0;
      cResetN = 1'b0; cWEn = 1'b0; cWAddr = '0; cWDat = '0; cWBe = '0; cREn = 1'b0; cRAddr = '0;

      tick();
      tick();
      checkOutput("resetBusyA", busyA, 1);
      checkOutput("resetBusyB", busyB, 1);
      checkOutput("resetValidA", rValidA, 0);
      checkOutput("resetDatA", rDatA, 0);
      checkOutput("resetValidB", rValidB, 0);
      checkOutput("resetBusyC", busyC, 0);
      checkOutput("resetValidC", rValidC, 0);
      checkOutput("resetDatC", rDatC, 0);

      // dutC: clear disabled, depth 300; out-of-range write is dropped.
      cResetN = 1'b1;
      checkOutput("busyCAfterRelease", busyC, 0);
      cWEn = 1'b1; cWAddr = 9'd144; cWDat = 32'h1111_2222; cWBe = 4'hF;
      tick();
      cWAddr = 9'd400; cWDat = 32'hCAFE_F00D;
      tick();
      cWEn = 1'b0; cREn = 1'b1; cRAddr = 9'd400;
      tick();
      checkOutput("cOorValid", rValidC, 1);
      checkOutput("cOorDat", rDatC, 32'h0);
      cRAddr = 9'd144;
      tick();
      checkOutput("c144Valid", rValidC, 1);
      checkOutput("c144Dat", rDatC, 32'h1111_2222);
      cREn = 1'b0;
      tick();
      checkOutput("cIdleValid", rValidC, 0);

      // Release dutA/dutB. User writes and reads during the clear must be ignored.
      resetN = 1'b1;
      wEn = 1'b1; wAddr = 9'd9; wDat = 32'hFFFF_FFFF; wBe = 4'hF; rEn = 1'b1; rAddr = 9'd0;
      countBusy(n, spurious);
      wEn = 1'b0; rEn = 1'b0;
      checkOutput("clearCycles", n, 512);
      checkOutput("clearSpuriousValid", spurious, 0);
      checkOutput("busyBAfterClear", busyB, 0);

      // Back-to-back reads of 0, 255 and 511 after the clear.
      applyStimulus(0, 0, 0, 0, 1, 9'd0);
      checkOutput("rd0ValidA", rValidA, 1);
      checkOutput("rd0DatA", rDatA, 0);
      checkOutput("rd0ValidBEarly", rValidB, 0);
      applyStimulus(0, 0, 0, 0, 1, 9'd255);
      checkOutput("rd255ValidA", rValidA, 1);
      checkOutput("rd0ValidB", rValidB, 1);
      applyStimulus(0, 0, 0, 0, 1, 9'd511);
      checkOutput("rd511ValidA", rValidA, 1);
      checkOutput("rd511DatA", rDatA, 0);
      tick();
      checkOutput("rdEndValidA", rValidA, 0);
      checkOutput("rd511ValidB", rValidB, 1);
      tick();
      checkOutput("rdEndValidB", rValidB, 0);

      // A word written during the clear must read back as zero.
      applyStimulus(0, 0, 0, 0, 1, 9'd9);
      checkOutput("clearIgnoredWrite", rDatA, 0);
      tick();

      // Byte-enable merge.
      applyStimulus(1, 9'd5, 32'hDEAD_BEEF, 4'hF, 0, 0);
      applyStimulus(1, 9'd5, 32'h00AA_0000, 4'h4, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 9'd5);
      checkOutput("beValidA", rValidA, 1);
      checkOutput("beDatA", rDatA, 32'hDEAA_BEEF);
      checkOutput("beValidBEarly", rValidB, 0);
      tick();
      checkOutput("bePulseA", rValidA, 0);
      checkOutput("beHoldA", rDatA, 32'hDEAA_BEEF);
      checkOutput("beValidB", rValidB, 1);
      checkOutput("beDatB", rDatB, 32'hDEAA_BEEF);
      applyStimulus(1, 9'd6, 32'h0000_0000, 4'h0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 9'd6);
      checkOutput("beZeroNoWrite", rDatA, 0);
      tick();

      // Read during write to the same address.
      applyStimulus(1, 9'd7, 32'h1234_5678, 4'hF, 1, 9'd7);
      checkOutput("rdwOldA", rDatA, 32'h0000_0000);
      tick();
      checkOutput("rdwNewB", rDatB, 32'h1234_5678);
      applyStimulus(0, 0, 0, 0, 1, 9'd7);
      checkOutput("rdwFollowA", rDatA, 32'h1234_5678);
      tick();
      checkOutput("rdwFollowB", rDatB, 32'h1234_5678);
      applyStimulus(1, 9'd7, 32'hAABB_CCDD, 4'h3, 1, 9'd7);
      checkOutput("rdwPartOldA", rDatA, 32'h1234_5678);
      tick();
      checkOutput("rdwPartMergedB", rDatB, 32'h1234_CCDD);
      applyStimulus(0, 0, 0, 0, 1, 9'd7);
      checkOutput("rdwPartFollowA", rDatA, 32'h1234_CCDD);
      tick();

      // Write and read at different addresses on the same edge are independent.
      applyStimulus(1, 9'd20, 32'h55AA_55AA, 4'hF, 1, 9'd21);
      checkOutput("indepA", rDatA, 0);
      tick();
      checkOutput("indepB", rDatB, 0);
      applyStimulus(0, 0, 0, 0, 1, 9'd20);
      checkOutput("indepFollowA", rDatA, 32'h55AA_55AA);
      tick();

      // Burst reads: A returns one word per cycle; B follows one cycle later.
      applyStimulus(1, 9'd1, 32'h1111_1111, 4'hF, 0, 0);
      applyStimulus(1, 9'd2, 32'h2222_2222, 4'hF, 0, 0);
      applyStimulus(1, 9'd3, 32'h3333_3333, 4'hF, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 9'd1);
      checkOutput("burstE1DatA", rDatA, 32'h1111_1111);
      checkOutput("burstE1ValidB", rValidB, 0);
      applyStimulus(0, 0, 0, 0, 1, 9'd2);
      checkOutput("burstE2DatA", rDatA, 32'h2222_2222);
      checkOutput("burstE2ValidB", rValidB, 1);
      checkOutput("burstE2DatB", rDatB, 32'h1111_1111);
      applyStimulus(0, 0, 0, 0, 1, 9'd3);
      checkOutput("burstE3DatA", rDatA, 32'h3333_3333);
      checkOutput("burstE3ValidB", rValidB, 1);
      checkOutput("burstE3DatB", rDatB, 32'h2222_2222);
      tick();
      checkOutput("burstE4ValidA", rValidA, 0);
      checkOutput("burstE4ValidB", rValidB, 1);
      checkOutput("burstE4DatB", rDatB, 32'h3333_3333);
      tick();
      checkOutput("burstE5ValidB", rValidB, 0);

      // Reset with reads in flight discards them.
      applyStimulus(0, 0, 0, 0, 1, 9'd5);
      applyStimulus(0, 0, 0, 0, 1, 9'd3);
      checkOutput("flightDatA", rDatA, 32'h3333_3333);
      checkOutput("flightDatB", rDatB, 32'hDEAA_BEEF);
      resetN = 1'b0;
      tick();
      checkOutput("flightDropA", rValidA, 0);
      checkOutput("flightDropB", rValidB, 0);
      checkOutput("flightDatBZero", rDatB, 0);
      checkOutput("flightBusy", busyA, 1);
      tick();
      checkOutput("flightStillDropB", rValidB, 0);

      // Reset in the middle of the clear restarts it from address 0.
      resetN = 1'b1;
      for (int i = 0; i < 100; i++) tick();
      checkOutput("midClearBusy", busyA, 1);
      resetN = 1'b0;
      tick();
      checkOutput("midResetBusy", busyA, 1);
      checkOutput("midResetValid", rValidA, 0);
      resetN = 1'b1;
      countBusy(n, spurious);
      checkOutput("reclearCycles", n, 512);
      checkOutput("reclearSpurious", spurious, 0);
      applyStimulus(0, 0, 0, 0, 1, 9'd5);
      checkOutput("reclear5A", rDatA, 0);
      applyStimulus(0, 0, 0, 0, 1, 9'd7);
      checkOutput("reclear7A", rDatA, 0);
      checkOutput("reclear5B", rDatB, 0);
      checkOutput("reclear5ValidB", rValidB, 1);
      tick();
      checkOutput("reclear7B", rDatB, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
